// File: rtl/aes_gcm_tag_stage.sv
// aes_gcm_tag_stage
// Terminal stage of the AES-GCM encrypt pipeline. Each accepted beat carries
// one counter-mode keystream block E(K,CB) and one plaintext block; the stage
// emits ciphertext = plaintext ^ E(K,CB). In parallel it runs GHASH over the
// single AAD block, every ciphertext block and the GCM length block, using a
// digit-serial GF(2^128) multiplier. Once per instance it emits the tag
// GHASH ^ E(K,J0).
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   i_valid/o_ready   beat handshake; o_ready is high only in IDLE/WAIT_DATA
//   i_new_instance    first beat of an instance (latches H, EJ0, AAD, sizes)
//   i_last            last beat of an instance (may coincide with new)
//   i_h               hash subkey H
//   i_encrypted_j0    E(K,J0), used to mask the final GHASH value
//   i_encrypted_cb    E(K,CB) for this beat
//   i_plain_text      plaintext block
//   i_aad             single zero-padded AAD block
//   i_instance_size   [0:63] AAD bit length, [64:127] text bit length
//   o_ct_valid        one-cycle ciphertext strobe
//   o_cipher_text     ciphertext, tail bits of a partial last block forced to 0
//   o_tag_valid       one-cycle tag strobe
//   o_tag             authentication tag
//
// All 128-bit vectors use GCM bit order: index 0 is the leftmost bit (x^0).
module aes_gcm_tag_stage #(
    parameter int DIGIT_BITS = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic         i_new_instance,
    input  logic         i_last,
    input  logic [0:127] i_h,
    input  logic [0:127] i_encrypted_j0,
    input  logic [0:127] i_encrypted_cb,
    input  logic [0:127] i_plain_text,
    input  logic [0:127] i_aad,
    input  logic [0:127] i_instance_size,
    output logic         o_ct_valid,
    output logic [0:127] o_cipher_text,
    output logic         o_tag_valid,
    output logic [0:127] o_tag
);

    localparam int           M          = 128 / DIGIT_BITS;
    localparam logic [6:0]   LAST_DIGIT = 7'(M - 1);
    localparam logic [0:127] R_POLY     = {8'he1, 120'd0};
    localparam logic [0:127] ALL_ONES   = '1;

    typedef enum logic [2:0] {
        IDLE,
        MUL_AAD,
        WAIT_DATA,
        MUL_DATA,
        MUL_LEN,
        DONE
    } state_t;

    state_t       state;
    logic [0:127] h_reg;
    logic [0:127] ej0_reg;
    logic [0:127] len_reg;
    logic [0:127] ct_reg;
    logic         last_reg;
    logic [0:127] z_reg;
    logic [0:127] v_reg;
    logic [0:127] x_reg;
    logic [6:0]   cnt;

    logic [0:127] z_next;
    logic [0:127] v_next;
    logic         accept;
    logic         start;
    logic         data_beat;
    logic [0:127] beat_len;
    logic [6:0]   rem_bits;
    logic [0:127] keep_mask;
    logic [0:127] ct_beat;
    logic         text_empty;
    logic         aad_empty;

    // The ready gate also looks at rst so that upstream never sees a
    // handshake complete on an edge where the stage is being reset.
    assign o_ready   = !rst && (state == IDLE || state == WAIT_DATA);
    assign accept    = i_valid && o_ready;
    assign start     = accept && i_new_instance;
    assign data_beat = accept && !i_new_instance && (state == WAIT_DATA);

    // A new-instance beat carries its own length block; later beats use the
    // one latched at the start of the instance.
    assign beat_len   = start ? i_instance_size : len_reg;
    assign rem_bits   = beat_len[121:127];
    assign text_empty = (i_instance_size[64:127] == 64'd0);
    assign aad_empty  = (i_instance_size[0:63] == 64'd0);

    // Only a partial final block is trimmed; bits [r:127] are cleared so the
    // same value feeds both the output and GHASH.
    assign keep_mask = (i_last && rem_bits != 7'd0) ? ~(ALL_ONES >> rem_bits) : ALL_ONES;
    assign ct_beat   = (i_plain_text ^ i_encrypted_cb) & keep_mask;

    // One digit of the shift-and-add multiply. x_reg is pre-shifted so the
    // next unconsumed X bit always sits at index 0; V is reduced by R after
    // every single-bit step.
    always_comb begin
        z_next = z_reg;
        v_next = v_reg;
        for (int i = 0; i < DIGIT_BITS; i++) begin
            if (x_reg[i]) begin
                z_next = z_next ^ v_next;
            end
            v_next = v_next[127] ? ((v_next >> 1) ^ R_POLY) : (v_next >> 1);
        end
    end

    // Control FSM and datapath registers. When one multiply finishes and the
    // next begins on the same edge, the new X operand is built straight from
    // z_next so no cycle is lost between phases. Between data beats the
    // running GHASH value Y is parked in z_reg.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            h_reg         <= '0;
            ej0_reg       <= '0;
            len_reg       <= '0;
            ct_reg        <= '0;
            last_reg      <= 1'b0;
            z_reg         <= '0;
            v_reg         <= '0;
            x_reg         <= '0;
            cnt           <= '0;
            o_ct_valid    <= 1'b0;
            o_cipher_text <= '0;
            o_tag_valid   <= 1'b0;
            o_tag         <= '0;
        end else begin
            o_ct_valid  <= 1'b0;
            o_tag_valid <= 1'b0;
            case (state)
                IDLE, WAIT_DATA: begin
                    if (start) begin
                        h_reg    <= i_h;
                        ej0_reg  <= i_encrypted_j0;
                        len_reg  <= i_instance_size;
                        ct_reg   <= ct_beat;
                        last_reg <= i_last;
                        z_reg    <= '0;
                        v_reg    <= i_h;
                        cnt      <= '0;
                        if (!text_empty) begin
                            o_cipher_text <= ct_beat;
                            o_ct_valid    <= 1'b1;
                        end
                        if (!aad_empty) begin
                            x_reg <= i_aad;
                            state <= MUL_AAD;
                        end else if (!text_empty) begin
                            x_reg <= ct_beat;
                            state <= MUL_DATA;
                        end else begin
                            x_reg <= i_instance_size;
                            state <= MUL_LEN;
                        end
                    end else if (data_beat) begin
                        ct_reg        <= ct_beat;
                        last_reg      <= i_last;
                        o_cipher_text <= ct_beat;
                        o_ct_valid    <= 1'b1;
                        x_reg         <= z_reg ^ ct_beat;
                        z_reg         <= '0;
                        v_reg         <= h_reg;
                        cnt           <= '0;
                        state         <= MUL_DATA;
                    end
                end
                MUL_AAD, MUL_DATA, MUL_LEN: begin
                    if (cnt == LAST_DIGIT) begin
                        cnt   <= '0;
                        z_reg <= '0;
                        v_reg <= h_reg;
                        if (state == MUL_AAD) begin
                            if (len_reg[64:127] == 64'd0) begin
                                x_reg <= z_next ^ len_reg;
                                state <= MUL_LEN;
                            end else begin
                                x_reg <= z_next ^ ct_reg;
                                state <= MUL_DATA;
                            end
                        end else if (state == MUL_DATA) begin
                            if (last_reg) begin
                                x_reg <= z_next ^ len_reg;
                                state <= MUL_LEN;
                            end else begin
                                z_reg <= z_next;
                                state <= WAIT_DATA;
                            end
                        end else begin
                            z_reg       <= z_next;
                            o_tag       <= z_next ^ ej0_reg;
                            o_tag_valid <= 1'b1;
                            state       <= DONE;
                        end
                    end else begin
                        cnt   <= cnt + 7'd1;
                        z_reg <= z_next;
                        v_reg <= v_next;
                        x_reg <= x_reg << DIGIT_BITS;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_gcm_tag_stage.sv
// tb_aes_gcm_tag_stage
// Directed bench for aes_gcm_tag_stage. The main DUT uses DIGIT_BITS = 8
// (M = 16); two extra instances with DIGIT_BITS = 1 and 32 share the data
// inputs and are only given a beat in the final parameter sweep.
module tb_aes_gcm_tag_stage;

    localparam int M8 = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         valid8 = 1'b0;
    logic         valid1 = 1'b0;
    logic         valid32 = 1'b0;
    logic         new_inst = 1'b0;
    logic         last = 1'b0;
    logic [0:127] h = '0;
    logic [0:127] ej0 = '0;
    logic [0:127] cb = '0;
    logic [0:127] pt = '0;
    logic [0:127] aad = '0;
    logic [0:127] size = '0;

    logic         ready8, ct_valid8, tag_valid8;
    logic [0:127] ct8, tag8;
    logic         ready1, ct_valid1, tag_valid1;
    logic [0:127] ct1, tag1;
    logic         ready32, ct_valid32, tag_valid32;
    logic [0:127] ct32, tag32;

    int vectors = 0;
    int miscompares = 0;

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    aes_gcm_tag_stage #(.DIGIT_BITS(8)) dut (
        .clk(clk), .rst(rst), .i_valid(valid8), .o_ready(ready8),
        .i_new_instance(new_inst), .i_last(last), .i_h(h),
        .i_encrypted_j0(ej0), .i_encrypted_cb(cb), .i_plain_text(pt),
        .i_aad(aad), .i_instance_size(size), .o_ct_valid(ct_valid8),
        .o_cipher_text(ct8), .o_tag_valid(tag_valid8), .o_tag(tag8)
    );

    aes_gcm_tag_stage #(.DIGIT_BITS(1)) dut1 (
        .clk(clk), .rst(rst), .i_valid(valid1), .o_ready(ready1),
        .i_new_instance(new_inst), .i_last(last), .i_h(h),
        .i_encrypted_j0(ej0), .i_encrypted_cb(cb), .i_plain_text(pt),
        .i_aad(aad), .i_instance_size(size), .o_ct_valid(ct_valid1),
        .o_cipher_text(ct1), .o_tag_valid(tag_valid1), .o_tag(tag1)
    );

    aes_gcm_tag_stage #(.DIGIT_BITS(32)) dut32 (
        .clk(clk), .rst(rst), .i_valid(valid32), .o_ready(ready32),
        .i_new_instance(new_inst), .i_last(last), .i_h(h),
        .i_encrypted_j0(ej0), .i_encrypted_cb(cb), .i_plain_text(pt),
        .i_aad(aad), .i_instance_size(size), .o_ct_valid(ct_valid32),
        .o_cipher_text(ct32), .o_tag_valid(tag_valid32), .o_tag(tag32)
    );

    // Bit-serial GF(2^128) product, one X bit at a time, used to build the
    // expected tag of the multi-block instance.
    function automatic logic [0:127] gf_mul(input logic [0:127] x, input logic [0:127] hk);
        logic [0:127] z;
        logic [0:127] v;
        z = '0;
        v = hk;
        for (int i = 0; i < 128; i++) begin
            if (x[i]) z = z ^ v;
            if (v[127]) v = (v >> 1) ^ {8'he1, 120'd0};
            else        v = v >> 1;
        end
        return z;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [0:127] observed, input logic [0:127] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic reportTimeout(input string tag);
        vectors++;
        miscompares++;
        $error("[TB] FAIL %s observed=timeout expected=o_ready high", tag);
    endtask

    // Present one beat to the main DUT and hold it until it is accepted.
    // Returns #1 after the accepting edge.
    task automatic applyStimulus(input logic n, input logic l, input logic [0:127] p, input logic [0:127] c);
        int waited;
        new_inst = n;
        last     = l;
        pt       = p;
        cb       = c;
        waited   = 0;
        while (!ready8 && waited < 2000) begin
            waited++;
            tick();
        end
        if (!ready8) reportTimeout("accept_wait");
        valid8 = 1'b1;
        tick();
        valid8 = 1'b0;
    endtask

    // Count cycles with o_ready low, noting the cycle (relative to the
    // accepting edge) where a tag strobe appears; 0 means no tag seen.
    task automatic watchWindow(output int low, output int tag_cyc, output logic [0:127] tag_val);
        low     = 0;
        tag_cyc = 0;
        tag_val = '0;
        while (!ready8 && low < 2000) begin
            if (tag_valid8) begin
                tag_cyc = low + 1;
                tag_val = tag8;
            end
            low++;
            tick();
        end
        if (!ready8) reportTimeout("ready_window");
    endtask

    // Directed sequence: reset, empty instance, single block, multi-block
    // with partial tail, abort, mid-instance reset, parameter sweep.
    initial begin
        logic [0:127] tc_h, tc_ej0, tc2_cb, tc2_tag;
        logic [0:127] mb_h, mb_ej0, mb_aad, mb_len, y, mb_tag;
        logic [0:127] mb_pt [4];
        logic [0:127] mb_cb [4];
        logic [0:127] mb_ct [4];
        logic [0:127] tv;
        int low, tcyc, c8, c1, c32;
        logic [0:127] t8v, t1v, t32v;
        logic seen;

        tc_h    = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
        tc_ej0  = 128'h58e2fccefa7e3061367f1d57a4e7455a;
        tc2_cb  = 128'h0388dace60b6a392f328c2b971b2fe78;
        tc2_tag = 128'hab6e47d42cec13bdf53a67b21257bddf;

        // Reset state
        tick();
        tick();
        checkOutput("rst_ready", 128'(ready8), 128'(0));
        checkOutput("rst_ct_valid", 128'(ct_valid8), 128'(0));
        checkOutput("rst_tag_valid", 128'(tag_valid8), 128'(0));
        checkOutput("rst_ct", ct8, '0);
        checkOutput("rst_tag", tag8, '0);
        rst = 1'b0;
        #1;
        checkOutput("rst_release_ready", 128'(ready8), 128'(1));

        // Empty instance: tag = EJ0 after M+1 cycles, no ciphertext
        h = tc_h; ej0 = tc_ej0; aad = '0; size = '0;
        applyStimulus(1'b1, 1'b1, 128'h1111, 128'h2222);
        checkOutput("empty_ct_valid", 128'(ct_valid8), 128'(0));
        watchWindow(low, tcyc, tv);
        checkOutput("empty_tag", tv, tc_ej0);
        checkOutput("empty_tag_cycle", 128'(tcyc), 128'(M8 + 1));

        // Single zero-key block
        size = {64'd0, 64'd128};
        applyStimulus(1'b1, 1'b1, '0, tc2_cb);
        checkOutput("tc2_ct_valid", 128'(ct_valid8), 128'(1));
        checkOutput("tc2_ct", ct8, 128'h0388dace60b6a392f328c2b971b2fe78);
        watchWindow(low, tcyc, tv);
        checkOutput("tc2_tag", tv, tc2_tag);
        checkOutput("tc2_tag_cycle", 128'(tcyc), 128'(2 * M8 + 1));
        checkOutput("tc2_ready_low", 128'(low), 128'(2 * M8 + 1));
        checkOutput("tc2_ct_hold", ct8, 128'h0388dace60b6a392f328c2b971b2fe78);

        // Multi-block: 96-bit AAD, 440-bit text, last block keeps 56 bits
        mb_h   = 128'hb83b533708bf535d0aa6e52980d53b78;
        mb_ej0 = 128'h3247184b3c4f69a44dbcd22887bbb418;
        mb_aad = 128'hfeedfacedeadbeeffeedface00000000;
        mb_len = {64'd96, 64'd440};
        mb_pt[0] = 128'hd9313225f88406e5a55909c5aff5269a;
        mb_cb[0] = 128'h3980ca0b3c00e841eb06fac4872a2757;
        mb_pt[1] = 128'h86a7a9531534f7da2e4c303d8a318a72;
        mb_cb[1] = 128'h0123456789abcdeffedcba9876543210;
        mb_pt[2] = 128'h1c3c0c95956809532fcf0e2449a6b525;
        mb_cb[2] = 128'ha5a5a5a5a5a5a5a55a5a5a5a5a5a5a5a;
        mb_pt[3] = 128'hb16aedf5aa0de657ba637b39ffffffff;
        mb_cb[3] = 128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f;
        mb_ct[0] = mb_pt[0] ^ mb_cb[0];
        mb_ct[1] = mb_pt[1] ^ mb_cb[1];
        mb_ct[2] = mb_pt[2] ^ mb_cb[2];
        mb_ct[3] = 128'hbe65e2faa502e9000000000000000000;
        y = gf_mul(mb_aad, mb_h);
        for (int i = 0; i < 4; i++) y = gf_mul(y ^ mb_ct[i], mb_h);
        y = gf_mul(y ^ mb_len, mb_h);
        mb_tag = y ^ mb_ej0;

        h = mb_h; ej0 = mb_ej0; aad = mb_aad; size = mb_len;
        applyStimulus(1'b1, 1'b0, mb_pt[0], mb_cb[0]);
        h = '0; ej0 = '0; aad = '0; size = '0;
        checkOutput("mb_ct0", ct8, mb_ct[0]);
        watchWindow(low, tcyc, tv);
        checkOutput("mb_beat0_ready_low", 128'(low), 128'(2 * M8));
        checkOutput("mb_beat0_no_tag", 128'(tcyc), 128'(0));
        applyStimulus(1'b0, 1'b0, mb_pt[1], mb_cb[1]);
        checkOutput("mb_ct1", ct8, mb_ct[1]);
        watchWindow(low, tcyc, tv);
        checkOutput("mb_beat1_ready_low", 128'(low), 128'(M8));
        applyStimulus(1'b0, 1'b0, mb_pt[2], mb_cb[2]);
        checkOutput("mb_ct2", ct8, mb_ct[2]);
        watchWindow(low, tcyc, tv);
        checkOutput("mb_beat2_ready_low", 128'(low), 128'(M8));
        applyStimulus(1'b0, 1'b1, mb_pt[3], mb_cb[3]);
        checkOutput("mb_ct3_masked", ct8, mb_ct[3]);
        watchWindow(low, tcyc, tv);
        checkOutput("mb_beat3_ready_low", 128'(low), 128'(2 * M8 + 1));
        checkOutput("mb_tag_cycle", 128'(tcyc), 128'(2 * M8 + 1));
        checkOutput("mb_tag", tv, mb_tag);

        // Abort: two-block instance interrupted by a new single-block instance
        h = mb_h; ej0 = mb_ej0; aad = '0; size = {64'd0, 64'd256};
        applyStimulus(1'b1, 1'b0, mb_pt[0], mb_cb[0]);
        watchWindow(low, tcyc, tv);
        checkOutput("abort_first_ready_low", 128'(low), 128'(M8));
        h = tc_h; ej0 = tc_ej0; size = {64'd0, 64'd128};
        applyStimulus(1'b1, 1'b1, '0, tc2_cb);
        checkOutput("abort_second_ct", ct8, tc2_cb);
        watchWindow(low, tcyc, tv);
        checkOutput("abort_second_tag", tv, tc2_tag);
        checkOutput("abort_second_tag_cycle", 128'(tcyc), 128'(2 * M8 + 1));

        // Reset during MUL_DATA clears outputs and suppresses the tag
        applyStimulus(1'b1, 1'b1, '0, tc2_cb);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        checkOutput("midrst_ready", 128'(ready8), 128'(0));
        checkOutput("midrst_ct_valid", 128'(ct_valid8), 128'(0));
        checkOutput("midrst_tag_valid", 128'(tag_valid8), 128'(0));
        checkOutput("midrst_ct", ct8, '0);
        checkOutput("midrst_tag", tag8, '0);
        rst = 1'b0;
        #1;
        checkOutput("midrst_ready_after", 128'(ready8), 128'(1));
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (tag_valid8) seen = 1'b1;
            tick();
        end
        checkOutput("midrst_no_tag", 128'(seen), 128'(0));

        // Parameter sweep: same instance into DIGIT_BITS 8, 1 and 32
        h = tc_h; ej0 = tc_ej0; aad = '0; size = {64'd0, 64'd128};
        new_inst = 1'b1; last = 1'b1; pt = '0; cb = tc2_cb;
        if (!(ready8 && ready1 && ready32)) reportTimeout("sweep_ready");
        valid8 = 1'b1; valid1 = 1'b1; valid32 = 1'b1;
        tick();
        valid8 = 1'b0; valid1 = 1'b0; valid32 = 1'b0;
        checkOutput("sweep_ct32", ct32, tc2_cb);
        c8 = 0; c1 = 0; c32 = 0;
        t8v = '0; t1v = '0; t32v = '0;
        for (int n = 1; n <= 400; n++) begin
            if (tag_valid8 && c8 == 0)   begin c8 = n;  t8v = tag8;   end
            if (tag_valid1 && c1 == 0)   begin c1 = n;  t1v = tag1;   end
            if (tag_valid32 && c32 == 0) begin c32 = n; t32v = tag32; end
            tick();
        end
        checkOutput("sweep_tag_d8", t8v, tc2_tag);
        checkOutput("sweep_tag_d1", t1v, tc2_tag);
        checkOutput("sweep_tag_d32", t32v, tc2_tag);
        checkOutput("sweep_cycle_d8", 128'(c8), 128'(2 * 16 + 1));
        checkOutput("sweep_cycle_d1", 128'(c1), 128'(2 * 128 + 1));
        checkOutput("sweep_cycle_d32", 128'(c32), 128'(2 * 4 + 1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
